// File: rtl/vlan_in_arb_pkg.sv
// Shared definitions for the VLAN-insertion input arbiter: stage number, FSM encoding, FIFO word layout.
package vlan_in_arb_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = DATA_W / 8;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;

  typedef enum logic [2:0] {
    ST_ARB  = 3'b001,
    ST_HDR  = 3'b010,
    ST_BODY = 3'b100
  } arb_state_t;

  // One buffered beat: ctrl sits above data, matching the FIFO's packed word.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small FIFO whose head word is visible on dout while not empty; rd_en pops it.
// Latency: a word written on one edge is readable in the next cycle. Backpressure: nearly_full with one slot left.
// Writes to a full FIFO and reads from an empty one are dropped.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (depth == '0);
  assign nearly_full = (depth >= NF_CNT);
  assign do_wr       = wr_en && (depth != FULL_CNT);
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      depth <= depth + 1'b1;
      else if (do_rd && !do_wr) depth <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/vlan_in_arb.sv
// Shares vlan_adder between NUM_QUEUES FIFO-buffered streams, one whole packet at a time (VLAN_ARB_STRICT_PRIO_EN: fixed priority).
// Latency: first word 3 cycles after in_wr, then 1 word/cycle; one idle ARB cycle between packets.
// Backpressure: out_rdy low blocks the read (out_wr low next cycle); in_rdy follows each FIFO's nearly_full.
module vlan_in_arb
  import vlan_in_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_QUEUES      = 4,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy
);

  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int FW = CTRL_WIDTH + DATA_WIDTH;

  logic [FW-1:0]         fifo_dout [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] fifo_empty;
  logic [NUM_QUEUES-1:0] fifo_nf;
  logic [NUM_QUEUES-1:0] fifo_rd;
  logic [NUM_QUEUES-1:0] req;

  arb_state_t            state, state_nxt;
  logic [QW-1:0]         grant, grant_nxt;
  logic [QW-1:0]         last_grant, last_grant_nxt;
  logic                  rd;
  word_t                 head;
  logic                  out_wr_nxt;
  logic [DATA_WIDTH-1:0] out_data_nxt;
  logic [CTRL_WIDTH-1:0] out_ctrl_nxt;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
    fallthrough_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .din         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en       (in_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (fifo_dout[i]),
      .nearly_full (fifo_nf[i]),
      .empty       (fifo_empty[i])
    );
    assign fifo_rd[i] = rd && (grant == QW'(i));
  end

  assign in_rdy = ~fifo_nf;
  assign req    = ~fifo_empty;
  assign head   = word_t'(fifo_dout[grant]);

  // Next grant among non-empty queues; round-robin search begins just after the last packet's owner.
  function automatic logic [QW-1:0] pick_next(input logic [NUM_QUEUES-1:0] r,
                                              input logic [QW-1:0] last);
`ifdef VLAN_ARB_STRICT_PRIO_EN
    logic [QW-1:0] sel;
    sel = last;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (r[QW'(i)]) sel = QW'(i);
    end
    return sel;
`else
    logic [QW-1:0] sel;
    logic [QW-1:0] ix;
    logic          found;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      ix = QW'((int'(last) + i) % NUM_QUEUES);
      if (!found && r[ix]) begin
        sel   = ix;
        found = 1'b1;
      end
    end
    return sel;
`endif
  endfunction

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    rd             = (state != ST_ARB) && out_rdy && !fifo_empty[grant];
    out_wr_nxt     = rd;
    out_data_nxt   = rd ? head.data : out_data;
    out_ctrl_nxt   = rd ? head.ctrl : out_ctrl;
    unique case (state)
      ST_ARB: begin
        if (|req) begin
          grant_nxt = pick_next(req, last_grant);
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (rd && head.ctrl == '0) state_nxt = ST_BODY;
      end
      ST_BODY: begin
        // First non-zero ctrl after the body is the EOP word.
        if (rd && head.ctrl != '0) begin
          state_nxt      = ST_ARB;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ARB;
      grant      <= '0;
      last_grant <= QW'(NUM_QUEUES - 1);
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      out_wr     <= out_wr_nxt;
      out_data   <= out_data_nxt;
      out_ctrl   <= out_ctrl_nxt;
    end
  end

endmodule

// File: tb/tb_vlan_in_arb.sv
// Directed and random traffic against a queue-based packet arbitration model of vlan_in_arb.
module tb_vlan_in_arb;
  import vlan_in_arb_pkg::*;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NQ*DW-1:0] in_data = '0;
  logic [NQ*CW-1:0] in_ctrl = '0;
  logic [NQ-1:0]    in_wr = '0;
  logic [NQ-1:0]    in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy = 1'b1;

  always #5 clk = ~clk;

  vlan_in_arb #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .FIFO_DEPTH_BITS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
  );

  int errors = 0;
  int checks = 0;

  word_t src[NQ][$];
  word_t mq[NQ][$];
  int m_phase, m_grant, m_last;
  logic exp_wr;
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_ctrl;

  int rdy_mode = 0;
  logic rdy_at_edge;
  logic [NQ-1:0] hold_q = '0;
  int tick_no = 0;
  int seq = 0;
  int order_log[$];
  logic o_inpkt = 1'b0, o_body = 1'b0;
  int first_wr_tick = -1, first_out_tick = -1;
  int n_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int q, input int w);
    logic [31:0] r;
    r = $urandom();
    return {q[3:0], seq[11:0], w[15:0], r};
  endfunction

  task automatic add_word(input int q, input logic [7:0] c, input int w);
    word_t x;
    x.ctrl = c;
    x.data = mkdata(q, w);
    src[q].push_back(x);
  endtask

  task automatic add_pkt(input int q, input int nh, input int nb);
    int w;
    seq++;
    w = 0;
    for (int h = 0; h < nh; h++) begin
      add_word(q, (h == 0) ? 8'hFF : 8'($urandom_range(1, 255)), w); w++;
    end
    for (int b = 0; b < nb; b++) begin
      add_word(q, 8'h00, w); w++;
    end
    add_word(q, 8'($urandom_range(1, 255)), w);
  endtask

  // Packet-level reference: grant a whole packet to the chosen non-empty queue, one ARB cycle between packets.
  function automatic int model_pick();
`ifdef VLAN_ARB_STRICT_PRIO_EN
    for (int i = 0; i < NQ; i++) if (mq[i].size() > 0) return i;
`else
    for (int i = 1; i <= NQ; i++) begin
      int idx;
      idx = (m_last + i) % NQ;
      if (mq[idx].size() > 0) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_grant = 0; m_last = NQ - 1;
    exp_wr = 1'b0; exp_data = '0; exp_ctrl = '0;
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      src[q].delete();
    end
    o_inpkt = 1'b0;
  endtask

  task automatic model_step();
    word_t w;
    int p;
    exp_wr = 1'b0;
    if (m_phase == 0) begin
      p = model_pick();
      if (p >= 0) begin
        m_grant = p;
        m_phase = 1;
      end
    end else if (out_rdy && mq[m_grant].size() > 0) begin
      w = mq[m_grant].pop_front();
      exp_wr = 1'b1; exp_data = w.data; exp_ctrl = w.ctrl;
      if (w.ctrl == 0) m_phase = 2;
      else if (m_phase == 2) begin
        m_phase = 0;
        m_last = m_grant;
      end
    end
    for (int q = 0; q < NQ; q++) begin
      if (in_wr[q]) begin
        w.ctrl = in_ctrl[q*CW +: CW];
        w.data = in_data[q*DW +: DW];
        mq[q].push_back(w);
      end
    end
  endtask

  task automatic tick();
    word_t w;
    tick_no++;
    in_wr = '0;
    for (int q = 0; q < NQ; q++) begin
      if (src[q].size() > 0 && !hold_q[q] && in_rdy[q]) begin
        w = src[q].pop_front();
        in_wr[q] = 1'b1;
        in_data[q*DW +: DW] = w.data;
        in_ctrl[q*CW +: CW] = w.ctrl;
        if (first_wr_tick < 0) first_wr_tick = tick_no;
      end
    end
    case (rdy_mode)
      1:       out_rdy = ~out_rdy;
      2:       out_rdy = ($urandom_range(0, 3) != 0);
      default: out_rdy = 1'b1;
    endcase
    rdy_at_edge = out_rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_wr", out_wr, exp_wr);
    if (exp_wr) begin
      chk("out_data", out_data, exp_data);
      chk("out_ctrl", out_ctrl, exp_ctrl);
    end
    if (!rdy_at_edge) chk("wr_after_rdy_low", out_wr, 1'b0);
    if (out_wr) begin
      n_out++;
      if (first_out_tick < 0) first_out_tick = tick_no;
      if (!o_inpkt) begin
        order_log.push_back(int'(out_data[63:60]));
        o_inpkt = 1'b1;
        o_body  = 1'b0;
      end
      if (out_ctrl == 0) o_body = 1'b1;
      else if (o_body) o_inpkt = 1'b0;
    end
  endtask

  function automatic bit busy();
    if (m_phase != 0) return 1'b1;
    for (int q = 0; q < NQ; q++) if (src[q].size() > 0 || mq[q].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(busy()), 64'(0));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_o;
    model_reset();
    #12;
    chk("rst_out_wr", out_wr, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_ctrl", out_ctrl, 8'h0);
    chk("rst_in_rdy", in_rdy, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();

    // Single packet on queue 2 with latency measurement.
    seq++;
    add_word(2, 8'hFF, 0); add_word(2, 8'h00, 1); add_word(2, 8'h00, 2); add_word(2, 8'h10, 3);
    first_wr_tick = -1; first_out_tick = -1; n_out = 0;
    drain(50);
    chk("first_word_latency", 64'(first_out_tick - first_wr_tick + 1), 64'(3));
    chk("q2_word_count", 64'(n_out), 64'(4));

    // Queues 0 and 1 loaded together.
    order_log.delete();
    add_pkt(0, 1, 3); add_pkt(1, 1, 3);
    drain(100);
    chk("two_q_len", 64'(order_log.size()), 64'(2));
    if (order_log.size() == 2) begin
      chk("two_q_first", 64'(order_log[0]), 64'(0));
      chk("two_q_second", 64'(order_log[1]), 64'(1));
    end

    // Queue 3 stalls mid-body while queue 0 waits with a full packet.
    order_log.delete();
    seq++;
    add_word(3, 8'hFF, 0); add_word(3, 8'h00, 1); add_word(3, 8'h00, 2);
    add_pkt(0, 1, 3);
    repeat (6) tick();
    repeat (4) begin
      tick();
`ifndef VLAN_ARB_STRICT_PRIO_EN
      chk("stall_no_wr", out_wr, 1'b0);
`endif
    end
    add_word(3, 8'h00, 3); add_word(3, 8'h22, 4);
    drain(100);
    chk("stall_len", 64'(order_log.size()), 64'(2));
    if (order_log.size() == 2) begin
`ifdef VLAN_ARB_STRICT_PRIO_EN
      chk("stall_first", 64'(order_log[0]), 64'(0));
      chk("stall_second", 64'(order_log[1]), 64'(3));
`else
      chk("stall_first", 64'(order_log[0]), 64'(3));
      chk("stall_second", 64'(order_log[1]), 64'(0));
`endif
    end

    // out_rdy toggling every cycle during a 6-word packet.
    n_out = 0;
    rdy_mode = 1;
    add_pkt(3, 1, 4);
    drain(100);
    rdy_mode = 0;
    chk("toggle_word_count", 64'(n_out), 64'(6));

    // All queues with three packets each.
    order_log.delete();
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < NQ; q++) add_pkt(q, 0, 1);
    drain(400);
    chk("rr_len", 64'(order_log.size()), 64'(12));
    for (int k = 0; k < 12 && k < order_log.size(); k++) begin
`ifdef VLAN_ARB_STRICT_PRIO_EN
      exp_o = k / 3;
`else
      exp_o = k % NQ;
`endif
      chk("rr_order", 64'(order_log[k]), 64'(exp_o));
    end

    // Asynchronous reset in the middle of a packet.
    add_pkt(0, 1, 6);
    repeat (6) tick();
    in_wr = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_wr", out_wr, 1'b0);
    chk("arst_out_data", out_data, 64'h0);
    chk("arst_out_ctrl", out_ctrl, 8'h0);
    chk("arst_in_rdy", in_rdy, 4'hF);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    order_log.delete();
    n_out = 0;
    add_pkt(1, 1, 2);
    drain(60);
    chk("post_rst_len", 64'(order_log.size()), 64'(1));
    if (order_log.size() == 1) chk("post_rst_q", 64'(order_log[0]), 64'(1));
    chk("post_rst_words", 64'(n_out), 64'(4));

    // Random traffic, random out_rdy and random upstream stalls.
    rdy_mode = 2;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        int q;
        q = $urandom_range(0, NQ - 1);
        if (src[q].size() < 20) add_pkt(q, $urandom_range(0, 2), $urandom_range(1, 5));
      end
      hold_q = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : '0;
      tick();
    end
    hold_q = '0;
    drain(3000);
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
